// File: rtl/conv_fetch_ctrl.sv
// conv_fetch_ctrl: sequences conv input fetch commands into an address burst and
// retires each command once its returned data beats have drained through the mux.
module conv_fetch_ctrl #(
   parameter int AW  = 14,
   parameter int LW  = 14,
   parameter int IFW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [AW-1:0]  cmd_addr,
   input  logic [LW-1:0]  cmd_len,
   input  logic           cmd_src,
   input  logic [2:0]     cmd_chan,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   output logic [IFW-1:0] info,
   output logic [AW-1:0]  m_addr,
   output logic           m_addr_first,
   output logic           m_addr_last,
   output logic           m_addr_valid,
   input  logic           m_addr_ready,
   input  logic           d_valid,
   input  logic           d_ready,
   input  logic           d_last,
   output logic           busy,
   output logic           done,
   output logic           err
);
   typedef enum logic [2:0] {IDLE, SETUP, ISSUE, DRAIN, DONE} state_t;
   state_t        r_state, w_nstate;
   logic [AW-1:0] r_base;
   logic [LW-1:0] r_len, r_idx, r_rcnt, w_idx_n, w_rcnt_n;
   logic          r_fin, w_fin_n, w_err_n;
   logic          w_acc, w_ah, w_beat, w_count, w_final, w_err_set;
   assign cmd_ready = (r_state == IDLE);
   assign w_acc     = cmd_valid & cmd_ready;
   assign w_ah      = m_addr_valid & m_addr_ready;
   assign w_beat    = d_valid & d_ready;
   assign w_count   = w_beat & ((r_state == ISSUE) | (r_state == DRAIN));
   assign w_final   = w_count & (r_rcnt == r_len) & ~r_fin;
   // beats outside a fetch, beats past the final one, and misplaced last flags are all protocol errors
   assign w_err_set = (w_beat & ~w_count) | (w_count & (r_fin | ((r_rcnt == r_len) != d_last)));
   always_comb begin
      w_nstate = r_state;
      w_idx_n  = w_ah ? r_idx + 1'b1 : r_idx;
      w_rcnt_n = w_count ? r_rcnt + 1'b1 : r_rcnt;
      w_fin_n  = r_fin | w_final;
      w_err_n  = (w_acc ? 1'b0 : err) | w_err_set;
      if (w_acc) begin
         w_idx_n  = '0;
         w_rcnt_n = '0;
         w_fin_n  = 1'b0;
      end
      case (r_state)
         IDLE:    w_nstate = w_acc ? SETUP : IDLE;
         SETUP:   w_nstate = ISSUE;
         ISSUE:   if (w_ah & m_addr_last) w_nstate = (r_fin | w_final) ? DONE : DRAIN;
         DRAIN:   if (w_final) w_nstate = DONE;
         DONE:    w_nstate = IDLE;
         default: w_nstate = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_base       <= '0;
         r_len        <= '0;
         r_idx        <= '0;
         r_rcnt       <= '0;
         r_fin        <= 1'b0;
         info         <= '0;
         m_addr       <= '0;
         m_addr_valid <= 1'b0;
         m_addr_first <= 1'b0;
         m_addr_last  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         r_state      <= w_nstate;
         r_idx        <= w_idx_n;
         r_rcnt       <= w_rcnt_n;
         r_fin        <= w_fin_n;
         err          <= w_err_n;
         if (w_acc) begin
            r_base <= cmd_addr;
            r_len  <= cmd_len;
            info   <= IFW'({cmd_src, cmd_chan});
         end
         // address outputs are precomputed from the next index so they are registered yet on time
         if (w_nstate == ISSUE) m_addr <= r_base + AW'(w_idx_n);
         m_addr_valid <= (w_nstate == ISSUE);
         m_addr_first <= (w_nstate == ISSUE) & (w_idx_n == '0);
         m_addr_last  <= (w_nstate == ISSUE) & (w_idx_n == r_len);
         busy         <= (w_nstate != IDLE);
         done         <= (w_nstate == DONE);
      end
   end
endmodule

// File: tb/tb_conv_fetch_ctrl.sv
// tb_conv_fetch_ctrl: directed bench for conv_fetch_ctrl; inputs change and outputs
// are checked on the falling edge, away from the active rising edge.
module tb_conv_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] cmd_addr;
   logic [13:0] cmd_len;
   logic        cmd_src;
   logic [2:0]  cmd_chan;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  info;
   logic [13:0] m_addr;
   logic        m_addr_first, m_addr_last, m_addr_valid, m_addr_ready;
   logic        d_valid, d_ready, d_last;
   logic        busy, done, err;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   conv_fetch_ctrl #(.AW(14), .LW(14), .IFW(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_src(cmd_src), .cmd_chan(cmd_chan),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .info(info),
      .m_addr(m_addr), .m_addr_first(m_addr_first), .m_addr_last(m_addr_last),
      .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready),
      .d_valid(d_valid), .d_ready(d_ready), .d_last(d_last),
      .busy(busy), .done(done), .err(err)
   );

   task automatic step;
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic addr_chk(input string tag, input logic [13:0] a, input logic f, input logic l);
      chk({tag, " valid"}, 32'(m_addr_valid), 32'd1);
      chk({tag, " addr"}, 32'(m_addr), 32'(a));
      chk({tag, " first"}, 32'(m_addr_first), 32'(f));
      chk({tag, " last"}, 32'(m_addr_last), 32'(l));
   endtask

   task automatic issue_cmd(input logic [13:0] a, input logic [13:0] l, input logic s, input logic [2:0] c);
      cmd_addr = a; cmd_len = l; cmd_src = s; cmd_chan = c; cmd_valid = 1'b1;
      step;
      cmd_valid = 1'b0;
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " err"}, 32'(err), 32'd0);
      chk({tag, " info"}, 32'(info), 32'd0);
      chk({tag, " m_addr"}, 32'(m_addr), 32'd0);
      chk({tag, " valid"}, 32'(m_addr_valid), 32'd0);
      chk({tag, " first"}, 32'(m_addr_first), 32'd0);
      chk({tag, " last"}, 32'(m_addr_last), 32'd0);
   endtask

   initial begin
      rst = 1'b1; cmd_addr = '0; cmd_len = '0; cmd_src = 1'b0; cmd_chan = '0; cmd_valid = 1'b0;
      m_addr_ready = 1'b1; d_valid = 1'b0; d_ready = 1'b1; d_last = 1'b0;
      step; step;
      rst = 1'b0;
      step;
      reset_chk("reset");

      // RAM fetch, data lags the addresses by two cycles so DRAIN is exercised
      issue_cmd(14'h0100, 14'd3, 1'b0, 3'd0);
      chk("ram setup busy", 32'(busy), 32'd1);
      chk("ram setup info", 32'(info), 32'h0);
      chk("ram setup valid", 32'(m_addr_valid), 32'd0);
      chk("ram setup cmd_ready", 32'(cmd_ready), 32'd0);
      step;
      for (int c = 0; c < 6; c++) begin
         if (c <= 3) addr_chk("ram issue", 14'h0100 + 14'(c), c == 0, c == 3);
         else chk("ram drain valid", 32'(m_addr_valid), 32'd0);
         chk("ram no done", 32'(done), 32'd0);
         d_valid = (c >= 2);
         d_last = (c == 5);
         step;
      end
      d_valid = 1'b0; d_last = 1'b0;
      chk("ram done", 32'(done), 32'd1);
      chk("ram err", 32'(err), 32'd0);
      step;
      chk("ram idle done", 32'(done), 32'd0);
      chk("ram idle busy", 32'(busy), 32'd0);
      chk("ram idle cmd_ready", 32'(cmd_ready), 32'd1);

      // SDRAM fetch with address backpressure on beat 0
      issue_cmd(14'h0200, 14'd1, 1'b1, 3'd3);
      chk("sdram info", 32'(info), 32'hB);
      m_addr_ready = 1'b0;
      step;
      for (int c = 0; c < 3; c++) begin
         addr_chk("sdram stall", 14'h0200, 1'b1, 1'b0);
         step;
      end
      m_addr_ready = 1'b1;
      addr_chk("sdram beat0", 14'h0200, 1'b1, 1'b0);
      step;
      addr_chk("sdram beat1", 14'h0201, 1'b0, 1'b1);
      step;
      chk("sdram drain valid", 32'(m_addr_valid), 32'd0);
      chk("sdram drain busy", 32'(busy), 32'd1);
      d_valid = 1'b1; d_last = 1'b0;
      step;
      chk("sdram wait done", 32'(done), 32'd0);
      d_last = 1'b1;
      step;
      d_valid = 1'b0; d_last = 1'b0;
      chk("sdram done", 32'(done), 32'd1);
      chk("sdram err", 32'(err), 32'd0);
      step;

      // address wrap at 2^14
      issue_cmd(14'h3FFF, 14'd1, 1'b0, 3'd5);
      chk("wrap info", 32'(info), 32'h5);
      step;
      addr_chk("wrap beat0", 14'h3FFF, 1'b1, 1'b0);
      d_valid = 1'b1; d_last = 1'b0;
      step;
      addr_chk("wrap beat1", 14'h0000, 1'b0, 1'b1);
      d_last = 1'b1;
      step;
      d_valid = 1'b0; d_last = 1'b0;
      chk("wrap done", 32'(done), 32'd1);
      chk("wrap err", 32'(err), 32'd0);
      step;

      // early d_last on the second beat
      issue_cmd(14'h0040, 14'd2, 1'b0, 3'd1);
      step;
      for (int c = 0; c < 3; c++) begin
         addr_chk("perr issue", 14'h0040 + 14'(c), c == 0, c == 2);
         if (c == 2) chk("perr err set", 32'(err), 32'd1);
         d_valid = 1'b1;
         d_last = (c >= 1);
         step;
      end
      d_valid = 1'b0; d_last = 1'b0;
      chk("perr done", 32'(done), 32'd1);
      chk("perr err held", 32'(err), 32'd1);
      step;
      chk("perr idle err", 32'(err), 32'd1);

      // single beat, data coincides with the address handshake; accept clears err
      issue_cmd(14'h0123, 14'd0, 1'b1, 3'd7);
      chk("single err cleared", 32'(err), 32'd0);
      chk("single info", 32'(info), 32'hF);
      step;
      addr_chk("single issue", 14'h0123, 1'b1, 1'b1);
      d_valid = 1'b1; d_last = 1'b1;
      step;
      d_valid = 1'b0; d_last = 1'b0;
      chk("single done", 32'(done), 32'd1);
      chk("single valid", 32'(m_addr_valid), 32'd0);
      chk("single err", 32'(err), 32'd0);
      step;

      // reset during ISSUE at idx 2
      issue_cmd(14'h0010, 14'd5, 1'b1, 3'd4);
      step;
      addr_chk("mrst idx0", 14'h0010, 1'b1, 1'b0);
      step;
      addr_chk("mrst idx1", 14'h0011, 1'b0, 1'b0);
      step;
      addr_chk("mrst idx2", 14'h0012, 1'b0, 1'b0);
      rst = 1'b1;
      step;
      rst = 1'b0;
      reset_chk("mrst");
      d_valid = 1'b1;
      step;
      d_valid = 1'b0;
      chk("stray err", 32'(err), 32'd1);
      issue_cmd(14'h2000, 14'd0, 1'b0, 3'd2);
      chk("post err cleared", 32'(err), 32'd0);
      chk("post info", 32'(info), 32'h2);
      step;
      addr_chk("post issue", 14'h2000, 1'b1, 1'b1);
      d_valid = 1'b1; d_last = 1'b1;
      step;
      d_valid = 1'b0; d_last = 1'b0;
      chk("post done", 32'(done), 32'd1);
      chk("post err", 32'(err), 32'd0);
      step;
      chk("post idle", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/conv_fetch_ctrl.md
# conv_fetch_ctrl

Sequencer for the conv input fetch path. It accepts fetch commands of base address, beat count, source memory and channel count, and drives the `info` select word and the address stream into the conv input mux. It then counts the data beats returned at the mux output and retires the command only when the last beat has drained. `info` is never changed while a fetch is in flight, so the mux's registered source select cannot switch mid-burst.

## Interface
Parameters:
- `AW`, 14, address width
- `LW`, 14, beat-count width
- `IFW`, 4, info width (bit 3 = source, bits 2:0 = channel count)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `cmd_addr`  in  AW  base address of burst
- `cmd_len`  in  LW  beats minus one (0 = 1 beat)
- `cmd_src`  in  1  0 = on-chip RAM, 1 = SDRAM picture
- `cmd_chan`  in  3  channel enable code, passed to `info[2:0]` (0 = all 8 channels)
- `cmd_valid`  in  1  command valid
- `cmd_ready`  out  1  command accepted when both high
- `info`  out  IFW  {src, chan} to conv input mux
- `m_addr`  out  AW  address beat
- `m_addr_first`  out  1  first address of burst
- `m_addr_last`  out  1  last address of burst
- `m_addr_valid`  out  1  address valid
- `m_addr_ready`  in  1  address accepted
- `d_valid`  in  1  monitored mux output valid
- `d_ready`  in  1  monitored mux output ready
- `d_last`  in  1  monitored mux output last flag
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when a command retires
- `err`  out  1  sticky protocol error, cleared on next command accept

## Operation
- States: IDLE, SETUP, ISSUE, DRAIN, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`: latch addr, len and src/chan; load `info` <= {cmd_src, cmd_chan}; clear `err`, the issue index and the return count; go to SETUP.
- SETUP:
  - Held for one cycle so the mux's registered select settles.
  - No address is driven.
  - Go to ISSUE.
- ISSUE:
  - `m_addr_valid`=1.
  - `m_addr` = base + idx, modulo 2^AW; the address wraps silently.
  - `m_addr_first` = (idx==0).
  - `m_addr_last` = (idx==len).
  - idx increments on each `m_addr_valid & m_addr_ready`.
  - On the handshake with last=1, go to DRAIN.
  - Address, first and last stay stable while ready is low.
- Return counting, active in ISSUE and DRAIN:
  - rcnt increments on `d_valid & d_ready`; the beat is final when rcnt==len.
  - A final beat with `d_last`=0 sets `err`.
  - A non-final beat with `d_last`=1 sets `err`.
- DRAIN:
  - Wait until the final beat is accepted; this beat may also arrive in ISSUE.
  - Then go to DONE; if the final beat and the last address handshake coincide, go directly from ISSUE to DONE.
- DONE:
  - `done`=1 for one cycle.
  - Go to IDLE.
- `info` holds its last value in IDLE and changes only on command accept.
- A `d_valid & d_ready` in IDLE, SETUP or DONE is ignored for counting and sets `err`.
- `cmd_ready` is 0 in every state except IDLE; a second command waits.

## Timing
- Reset values: state IDLE, `info`=0, `m_addr`=0, `m_addr_valid`=0, `m_addr_first`=0, `m_addr_last`=0, `cmd_ready`=1, `busy`=0, `done`=0, `err`=0, counters 0.
- A reset asserted mid-operation aborts the fetch immediately. Beats returned after reset fall into IDLE and flag `err`; software reissues the command.
- Command accepted at edge T:
  - `info` and `busy` are valid from T+1 (SETUP).
  - The first `m_addr_valid` is at T+2.
- With `m_addr_ready` held high, one address per cycle; the last address is at T+2+len.
- `done` is asserted the cycle after the final data beat is accepted, or after the last address handshake if that is later.
- The earliest next command accept is the cycle after `done`.
- All outputs are registered except `cmd_ready`, which decodes the state register.

## Test plan
- RAM fetch: cmd addr=0x0100, len=3, src=0, chan=0, ready always high.
  - `info`=4'h0 at T+1.
  - Addresses 0x100..0x103 at T+2..T+5, first on 0x100, last on 0x103.
  - 4 returned beats with `d_last` on the 4th -> `done` one cycle after the 4th beat, `err`=0.
- SDRAM fetch with backpressure: src=1, chan=3, len=1.
  - `info`=4'hB.
  - `m_addr_ready` low for 3 cycles on beat 0 -> addr/first held stable, then 2 beats issued, `done` after 2 returns.
- Wrap: addr=0x3FFF, len=1, AW=14 -> addresses 0x3FFF, then 0x0000 with last=1.
- Protocol error: len=2, `d_last` asserted on the 2nd beat -> `err`=1 and stays set. The next command accept clears it.
- Single beat / coincident completion: len=0, data returns in the same cycle as the address handshake -> `first`=`last`=1, ISSUE goes directly to DONE, `done` one cycle later.
- Mid-burst reset: `rst` high during ISSUE at idx=2 -> next cycle all outputs at reset values. A subsequent stray `d_valid & d_ready` sets `err`, and a new command runs normally.
